main_mem_ctrl: RTL and testbench
================================

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 9, memory byte-address width.
REQ-002 SHALL have parameter DWIDTH, default 8, byte-lane width.
REQ-003 SHALL have parameter BLOCKSIZE, default 4, bytes per burst (cache line).
REQ-004 SHALL have parameter LATENCY, default 2, access wait cycles, legal range 1..15.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port addr_mem, input, AWIDTH, burst start address from the cache controller.
REQ-008 SHALL have port rd_mem, input, 1, read-burst request.
REQ-009 SHALL have port wr_mem, input, 1, write-burst request; also qualifies each write byte.
REQ-010 SHALL have port wmem_byte, input, DWIDTH, write data byte.
REQ-011 SHALL have port data_mem, output, DWIDTH, read data byte.
REQ-012 SHALL have port rvalid_mem, output, 1, data_mem holds a valid burst byte.
REQ-013 SHALL have port ready_mem, output, 1, controller idle and able to accept a request.

Function
REQ-014 SHALL hold 2**AWIDTH bytes of storage; contents undefined until written.
REQ-015 SHALL use states IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT.
REQ-016 SHALL drive ready_mem=1 only in IDLE.
REQ-017 In IDLE with wr_mem=1, SHALL latch base={addr_mem[AWIDTH-1:2],2'b00}, capture wmem_byte as byte 0, and go to WR_BURST.
REQ-018 In IDLE with rd_mem=1 and wr_mem=0, SHALL latch base aligned the same way and go to RD_WAIT.
REQ-019 When rd_mem and wr_mem are both 1 in IDLE, SHALL take the write.
REQ-020 In WR_BURST, SHALL store wmem_byte to base+k on each cycle with wr_mem=1, where k is a 2-bit byte index incremented only on those cycles.
REQ-021 Cycles in WR_BURST with wr_mem=0 SHALL be stalls that change neither storage nor k.
REQ-022 After byte BLOCKSIZE-1 is stored, SHALL go to WR_WAIT for LATENCY cycles, then return to IDLE.
REQ-023 In RD_WAIT, SHALL count LATENCY cycles, then go to RD_BURST.
REQ-024 In RD_BURST, SHALL drive data_mem=mem[base+k] with rvalid_mem=1 on BLOCKSIZE consecutive cycles, k=0..3, with no stalls.
REQ-025 After the last read byte, SHALL return to IDLE.
REQ-026 SHALL produce first read data exactly LATENCY+1 cycles after the request cycle.
REQ-027 Request inputs SHALL be ignored outside IDLE, except wr_mem in WR_BURST.
REQ-028 Byte-address arithmetic SHALL be AWIDTH bits; only k wraps (3->0); base never overflows.
REQ-029 data_mem SHALL read 0 whenever rvalid_mem=0.

Reset
REQ-030 On reset=1 at a clock edge, SHALL go to IDLE, set ready_mem=1, rvalid_mem=0, data_mem=0, k=0 and the latency counter to 0.
REQ-031 Reset during any burst SHALL abort it; bytes already stored SHALL remain, and storage SHALL never be cleared by reset.

Structure
REQ-032 SHALL place the state enum and the AWIDTH/DWIDTH/BLOCKSIZE defaults in shared package cache_pkg.
REQ-033 SHALL instantiate storage as sub-module ram_sync_byte: single port, synchronous write, combinational read.
REQ-034 SHALL contain one FSM with a 2-bit byte index and a 4-bit latency counter.

Verification
REQ-035 Write then read: write burst 0xAA,0xBB,0xCC,0xDD at addr 0x1A3; then read at 0x1A0 -> data_mem 0xAA,0xBB,0xCC,0xDD; first byte 3 cycles after rd_mem; ready_mem=1 one cycle after the last byte.
REQ-036 Write stall: wr_mem pattern 1,1,0,1,1 with bytes 01,02,xx,03,04 -> memory holds 01,02,03,04 at the aligned base.
REQ-037 Simultaneous request: rd_mem=wr_mem=1 in IDLE -> write burst taken, and no rvalid_mem pulse follows.
REQ-038 Reset mid-burst: reset after 2 write bytes -> ready_mem=1 next cycle; readback shows bytes 0-1 new and bytes 2-3 unchanged.
REQ-039 Top of memory: burst at addr 0x1FF -> base 0x1FC, bytes land at 0x1FC..0x1FF with no wrap to 0x000.
REQ-040 LATENCY=5 build: read first byte appears exactly 6 cycles after the request.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the main-memory controller and its byte RAM.
package cache_pkg;

  localparam int AWIDTH_DEF    = 9;
  localparam int DWIDTH_DEF    = 8;
  localparam int BLOCKSIZE_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_WAIT
  } state_t;

endpackage

// File: rtl/ram_sync_byte.sv
// Single-port byte RAM: synchronous write, combinational read; never cleared.
module ram_sync_byte #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/main_mem_ctrl.sv
// Burst main-memory controller: line-aligned 4-byte read/write bursts with a fixed
// access latency in front of reads and behind writes.
module main_mem_ctrl
  import cache_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int BLOCKSIZE = BLOCKSIZE_DEF,
  parameter int LATENCY   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AWIDTH-1:0] addr_mem,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DWIDTH-1:0] wmem_byte,
  output logic [DWIDTH-1:0] data_mem,
  output logic              rvalid_mem,
  output logic              ready_mem,
  output state_t            state_dbg
);

  // Handshake: a request is accepted on any rising edge where ready_mem=1 and
  // rd_mem or wr_mem is high; during a write burst wr_mem=1 qualifies each byte.

  localparam logic [1:0] LAST_K    = 2'(BLOCKSIZE - 1);
  localparam logic [3:0] LAST_WAIT = 4'(LATENCY - 1);

  state_t            state;
  logic [AWIDTH-1:0] base;
  logic [1:0]        k;
  logic [3:0]        wait_cnt;
  logic [AWIDTH-1:0] aligned;
  logic [AWIDTH-1:0] ram_addr;
  logic              ram_we;
  logic [DWIDTH-1:0] ram_rdata;

  assign aligned   = addr_mem & ~AWIDTH'(3);
  assign state_dbg = state;

  // Byte 0 of a write lands in the request cycle, straight from the aligned input address.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = base + AWIDTH'(k);
    if (state == IDLE) begin
      ram_addr = aligned;
      ram_we   = wr_mem & ~reset;
    end else if (state == WR_BURST) begin
      ram_we = wr_mem & ~reset;
    end
  end

  ram_sync_byte #(.AW(AWIDTH), .DW(DWIDTH)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wmem_byte),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ready_mem  <= 1'b1;
      rvalid_mem <= 1'b0;
      data_mem   <= '0;
      k          <= '0;
      wait_cnt   <= '0;
      base       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_mem) begin
            base      <= aligned;
            k         <= 2'd1;
            ready_mem <= 1'b0;
            state     <= WR_BURST;
          end else if (rd_mem) begin
            base      <= aligned;
            k         <= '0;
            wait_cnt  <= '0;
            ready_mem <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            state    <= RD_BURST;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RD_BURST: begin
          // k back at 0 with a byte on the bus means the last byte has been shown.
          if (rvalid_mem && k == 2'd0) begin
            rvalid_mem <= 1'b0;
            data_mem   <= '0;
            ready_mem  <= 1'b1;
            state      <= IDLE;
          end else begin
            data_mem   <= ram_rdata;
            rvalid_mem <= 1'b1;
            k          <= (k == LAST_K) ? 2'd0 : k + 2'd1;
          end
        end
        WR_BURST: begin
          if (wr_mem) begin
            if (k == LAST_K) begin
              k        <= '0;
              wait_cnt <= '0;
              state    <= WR_WAIT;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        WR_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            wait_cnt  <= '0;
            ready_mem <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: per-cycle timeline model of ready/rvalid/data plus literal
// readback checks; a second LATENCY=5 instance pins the read latency.
module tb_main_mem_ctrl;
  import cache_pkg::*;

  localparam int AW   = 9;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int MAXC = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [AW-1:0] addr_mem;
  logic          rd_mem, wr_mem;
  logic [DW-1:0] wmem_byte, data_mem;
  logic          rvalid_mem, ready_mem;
  state_t        state_dbg;

  logic [AW-1:0] r5_addr = '0;
  logic          r5_rd = 1'b0, r5_wr = 1'b0;
  logic [DW-1:0] r5_wb = '0, r5_data;
  logic          r5_rvalid, r5_ready;
  state_t        r5_state;

  main_mem_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .BLOCKSIZE(4), .LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset), .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .wmem_byte(wmem_byte), .data_mem(data_mem), .rvalid_mem(rvalid_mem),
    .ready_mem(ready_mem), .state_dbg(state_dbg)
  );

  main_mem_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .BLOCKSIZE(4), .LATENCY(5)) u_dut5 (
    .clock(clock), .reset(reset), .addr_mem(r5_addr), .rd_mem(r5_rd), .wr_mem(r5_wr),
    .wmem_byte(r5_wb), .data_mem(r5_data), .rvalid_mem(r5_rvalid),
    .ready_mem(r5_ready), .state_dbg(r5_state)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int first_rv = -1;
  int req_edge = 0;

  // Expected outputs indexed by the number of the clock edge just taken.
  logic          exp_rdy [MAXC];
  logic          exp_rv  [MAXC];
  logic [DW-1:0] exp_d   [MAXC];
  logic [DW-1:0] mm      [2**AW];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en && cyc < MAXC) begin
      check("ready_mem", 32'(ready_mem), 32'(exp_rdy[cyc]));
      check("rvalid_mem", 32'(rvalid_mem), 32'(exp_rv[cyc]));
      check("data_mem", 32'(data_mem), 32'(exp_d[cyc]));
      if (rvalid_mem === 1'b1) begin
        got_q.push_back(data_mem);
        if (first_rv < 0) first_rv = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    rd_mem = 1'b0; wr_mem = 1'b0; addr_mem = '0; wmem_byte = '0;
  endtask

  task automatic junk_in();
    rd_mem = 1'($urandom_range(0, 1));
    wr_mem = 1'($urandom_range(0, 1));
    addr_mem = AW'($urandom_range(0, 511));
    wmem_byte = DW'($urandom_range(0, 255));
  endtask

  // Entry i drives wr_mem=en[i] and byte bytes[8*i+:8]; entry 0 is the request.
  task automatic do_write(input logic [AW-1:0] addr, input logic rd_first, input int n,
                          input logic [7:0] en, input logic [63:0] bytes);
    logic [AW-1:0] base;
    int k, e, last;
    base = addr & 9'h1FC;
    k = 0;
    last = -1;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        addr_mem = addr; rd_mem = rd_first;
      end else begin
        addr_mem = AW'($urandom_range(0, 511)); rd_mem = 1'($urandom_range(0, 1));
      end
      wr_mem = en[i];
      wmem_byte = en[i] ? bytes[8*i +: 8] : DW'($urandom_range(0, 255));
      e = cyc + 1;
      exp_rdy[e] = 1'b0;
      if (en[i] && k < 4) begin
        mm[base + AW'(k)] = bytes[8*i +: 8];
        k++;
        if (k == 4) last = e;
      end
      tick();
    end
    if (last >= 0) begin
      for (int j = 1; j <= LAT; j++) begin
        if (j < LAT) exp_rdy[last + j] = 1'b0;
        junk_in();
        tick();
      end
    end
    idle_in();
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    logic [AW-1:0] base;
    int e;
    base = addr & 9'h1FC;
    e = cyc + 1;
    rd_mem = 1'b1; wr_mem = 1'b0; addr_mem = addr; wmem_byte = DW'($urandom_range(0, 255));
    for (int c = e; c <= e + LAT + 4; c++) exp_rdy[c] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_rv[e + LAT + 1 + i] = 1'b1;
      exp_d[e + LAT + 1 + i] = mm[base + AW'(i)];
    end
    got_q.delete();
    first_rv = -1;
    req_edge = e;
    tick();
    for (int j = 1; j <= LAT + 5; j++) begin
      junk_in();
      tick();
    end
    idle_in();
  endtask

  task automatic do_reset();
    int e;
    reset = 1'b1;
    idle_in();
    e = cyc + 1;
    for (int c = e; c < e + 8; c++) begin
      exp_rdy[c] = 1'b1; exp_rv[c] = 1'b0; exp_d[c] = '0;
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic check_block(input string name, input logic [31:0] lit);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(lit[31 - 8*i -: 8]);
    check({name, "_count"}, 32'(got_q.size()), 32'd4);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(name, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int c = 0; c < MAXC; c++) begin
      exp_rdy[c] = 1'b1; exp_rv[c] = 1'b0; exp_d[c] = '0;
    end
    for (int a = 0; a < 2**AW; a++) mm[a] = '0;
    idle_in();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_ready", 32'(ready_mem), 32'd1);
    check("reset_rvalid", 32'(rvalid_mem), 32'd0);
    check("reset_data", 32'(data_mem), 32'd0);

    // Write then read back, misaligned request address.
    do_write(9'h1A3, 1'b0, 4, 8'h0F, 64'h0000_0000_DDCC_BBAA);
    do_read(9'h1A0);
    check_block("wr_rd_data", 32'hAABBCCDD);
    check("wr_rd_latency", 32'(first_rv - req_edge), 32'd3);

    // Write stall pattern 1,1,0,1,1.
    do_write(9'h0A5, 1'b0, 5, 8'h1B, 64'h0000_0004_03EE_0201);
    do_read(9'h0A4);
    check_block("stall_data", 32'h01020304);

    // Simultaneous read and write: write wins, no read data follows.
    got_q.delete();
    do_write(9'h012, 1'b1, 4, 8'h0F, 64'h0000_0000_1312_1110);
    check("both_req_no_rvalid", 32'(got_q.size()), 32'd0);
    do_read(9'h010);
    check_block("both_req_data", 32'h10111213);

    // Reset after two bytes of a write burst.
    do_write(9'h120, 1'b0, 4, 8'h0F, 64'h0000_0000_4433_2211);
    do_write(9'h121, 1'b0, 2, 8'h03, 64'h0000_0000_0000_6655);
    do_reset();
    check("abort_ready", 32'(ready_mem), 32'd1);
    do_read(9'h120);
    check_block("abort_data", 32'h55663344);

    // Top of memory: no wrap into address 0.
    do_write(9'h000, 1'b0, 4, 8'h0F, 64'h0000_0000_E3E2_E1E0);
    do_write(9'h1FF, 1'b0, 4, 8'h0F, 64'h0000_0000_F4F3_F2F1);
    do_read(9'h1FC);
    check_block("top_data", 32'hF1F2F3F4);
    do_read(9'h000);
    check_block("bottom_intact", 32'hE0E1E2E3);

    // LATENCY=5 instance: first read byte six cycles after the request.
    r5_addr = 9'h041;
    r5_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r5_wb = DW'(8'h5A + i);
      tick();
    end
    r5_wr = 1'b0;
    n = 0;
    while (r5_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("lat5_ready_timeout", 32'(n < 50), 32'd1);
    r5_addr = 9'h040;
    r5_rd = 1'b1;
    tick();
    r5_rd = 1'b0;
    n = 0;
    while (r5_rvalid !== 1'b1 && n < 30) begin tick(); n++; end
    check("lat5_first_byte", 32'(n), 32'd6);
    check("lat5_data", 32'(r5_data), 32'h5A);
    repeat (8) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
